// File: rtl/alu_pkg.sv
// alu_pkg: opcode and mode encodings shared by the alu_pipe slice
package alu_pkg;
  typedef enum logic [1:0] {OP1, OP2, OP3, OP4} opcode_t;
  typedef enum logic {MODE_A, MODE_B} mode_t;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation/result handshake, irq and counter bundle for alu_pipe
interface alu_pipe_if import alu_pkg::*; #(parameter int DATA_W = 8);
  logic alu_in_valid;
  logic alu_in_ready;
  mode_t alu_mode;
  opcode_t alu_op;
  logic [DATA_W-1:0] alu_in_a;
  logic [DATA_W-1:0] alu_in_b;
  logic alu_out_valid;
  logic alu_out_ready;
  logic [DATA_W-1:0] alu_out;
  logic alu_irq;
  logic alu_irq_clr;
  logic [15:0] alu_op_cnt;
  modport slave (
    input alu_in_valid, alu_mode, alu_op, alu_in_a, alu_in_b, alu_out_ready, alu_irq_clr,
    output alu_in_ready, alu_out_valid, alu_out, alu_irq, alu_op_cnt
  );
  modport master (
    output alu_in_valid, alu_mode, alu_op, alu_in_a, alu_in_b, alu_out_ready, alu_irq_clr,
    input alu_in_ready, alu_out_valid, alu_out, alu_irq, alu_op_cnt
  );
endinterface

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: combinational decode of both op sets
module alu_pipe_core import alu_pkg::*; #(parameter int DATA_W = 8) (
  input mode_t mode,
  input opcode_t op,
  input logic [DATA_W-1:0] a,
  input logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W-1:0] ra, rb;
  // set A is pure logic, set B adds xnor/or-not and a carry-dropping add
  always_comb begin
    ra = op == OP1 ? a & b : op == OP2 ? a & ~b : op == OP3 ? a | b : a ^ b;
    rb = op == OP1 ? ~(a ^ b) : op == OP2 ? a & b : op == OP3 ? a | ~b : a + b;
    result = mode == MODE_B ? rb : ra;
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage valid/ready ALU with sticky match irq; ALU_PIPE_OPCNT_EN adds a saturating op counter
module alu_pipe import alu_pkg::*; #(
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] IRQ_MATCH = {DATA_W{1'b1}}
) (
  input logic alu_clk,
  input logic alu_rst,
  alu_pipe_if.slave bus
);
  logic rdy_en, s1_v, s2_v, s1_adv, s2_take, accept, irq;
  mode_t s1_mode;
  opcode_t s1_op;
  logic [DATA_W-1:0] s1_a, s1_b, s2_d, res;
  assign s2_take = s2_v & bus.alu_out_ready;
  assign s1_adv = s1_v & (!s2_v | s2_take);
  assign bus.alu_in_ready = rdy_en & (!s1_v | s1_adv);
  assign accept = bus.alu_in_valid & bus.alu_in_ready;
  assign bus.alu_out_valid = s2_v;
  assign bus.alu_out = s2_v ? s2_d : '0;
  assign bus.alu_irq = irq;
  alu_pipe_core #(.DATA_W(DATA_W)) u_core (
    .mode(s1_mode),
    .op(s1_op),
    .a(s1_a),
    .b(s1_b),
    .result(res)
  );
  // ready is held low through reset and rises on the first edge after release
  always_ff @(posedge alu_clk or posedge alu_rst)
    if (alu_rst) rdy_en <= 1'b0;
    else rdy_en <= 1'b1;
  // S1 captures the offered operation; it empties when it advances without a refill
  always_ff @(posedge alu_clk or posedge alu_rst)
    if (alu_rst) begin
      s1_v <= 1'b0;
      s1_mode <= MODE_A;
      s1_op <= OP1;
      s1_a <= '0;
      s1_b <= '0;
    end else begin
      s1_v <= accept | (s1_v & !s1_adv);
      if (accept) begin
        s1_mode <= bus.alu_mode;
        s1_op <= bus.alu_op;
        s1_a <= bus.alu_in_a;
        s1_b <= bus.alu_in_b;
      end
    end
  // S2 holds the result until the consumer takes it
  always_ff @(posedge alu_clk or posedge alu_rst)
    if (alu_rst) begin
      s2_v <= 1'b0;
      s2_d <= '0;
    end else begin
      s2_v <= s1_adv | (s2_v & !s2_take);
      if (s1_adv) s2_d <= res;
    end
  // a matching result entering S2 sets the irq and beats a simultaneous clear
  always_ff @(posedge alu_clk or posedge alu_rst)
    if (alu_rst) irq <= 1'b0;
    else irq <= (s1_adv && res == IRQ_MATCH) | (irq & !bus.alu_irq_clr);
`ifdef ALU_PIPE_OPCNT_EN
  logic [15:0] cnt;
  // count output handshakes, sticking at all ones
  always_ff @(posedge alu_clk or posedge alu_rst)
    if (alu_rst) cnt <= '0;
    else if (s2_take && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  assign bus.alu_op_cnt = cnt;
`else
  assign bus.alu_op_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: vector table, corner sequences and randomized model check for alu_pipe
module tb_alu_pipe;
  import alu_pkg::*;
  localparam logic [7:0] MATCH = 8'hFF;
`ifdef ALU_PIPE_OPCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef struct {logic m; logic [1:0] o; logic [7:0] a; logic [7:0] b; logic [7:0] exp;} vec_t;
  typedef struct {logic [7:0] val; int edge_n; bit seen;} item_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  alu_pipe_if #(.DATA_W(8)) bus();
  alu_pipe #(.DATA_W(8)) dut (.alu_clk(clk), .alu_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic m, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    if (!m) begin
      case (o)
        2'd0: return a & b;
        2'd1: return a & ~b;
        2'd2: return a | b;
        default: return a ^ b;
      endcase
    end
    case (o)
      2'd0: return ~(a ^ b);
      2'd1: return a & b;
      2'd2: return a | ~b;
      default: return 8'((int'(a) + int'(b)) % 256);
    endcase
  endfunction

  task automatic drive(input logic v, input logic m, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    bus.alu_in_valid = v;
    bus.alu_mode = mode_t'(m);
    bus.alu_op = opcode_t'(o);
    bus.alu_in_a = a;
    bus.alu_in_b = b;
  endtask

  initial begin
    vec_t tv[10];
    vec_t s4[4];
    item_t q[$];
    item_t it;
    int sent, got, stall, cnt_e;
    bit full, irq_e, pclr, set_ev, ev, rdy_e;
    tv[0] = '{1'b0, 2'd0, 8'hF0, 8'h3C, 8'h30};
    tv[1] = '{1'b1, 2'd3, 8'hFF, 8'h02, 8'h01};
    tv[2] = '{1'b0, 2'd0, 8'hCA, 8'h5C, 8'h48};
    tv[3] = '{1'b0, 2'd1, 8'hCA, 8'h5C, 8'h82};
    tv[4] = '{1'b0, 2'd2, 8'hCA, 8'h5C, 8'hDE};
    tv[5] = '{1'b0, 2'd3, 8'hCA, 8'h5C, 8'h96};
    tv[6] = '{1'b1, 2'd0, 8'hCA, 8'h5C, 8'h69};
    tv[7] = '{1'b1, 2'd1, 8'hCA, 8'h5C, 8'h48};
    tv[8] = '{1'b1, 2'd2, 8'hCA, 8'h5C, 8'hEB};
    tv[9] = '{1'b1, 2'd3, 8'hCA, 8'h5C, 8'h26};
    s4[0] = '{1'b0, 2'd0, 8'hA5, 8'h3C, 8'h00};
    s4[1] = '{1'b1, 2'd3, 8'h80, 8'h90, 8'h00};
    s4[2] = '{1'b0, 2'd3, 8'h55, 8'h0F, 8'h00};
    s4[3] = '{1'b1, 2'd2, 8'h0F, 8'hF0, 8'h00};
    for (int i = 0; i < 4; i++) s4[i].exp = ref_op(s4[i].m, s4[i].o, s4[i].a, s4[i].b);
    drive(0, 0, 0, 0, 0);
    bus.alu_out_ready = 1'b0;
    bus.alu_irq_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", bus.alu_out_valid, 0);
    chk("rst_out", bus.alu_out, 0);
    chk("rst_in_ready", bus.alu_in_ready, 0);
    chk("rst_irq", bus.alu_irq, 0);
    chk("rst_op_cnt", bus.alu_op_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rdy_before_edge", bus.alu_in_ready, 0);
    @(negedge clk);
    #1 chk("rdy_after_edge", bus.alu_in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.alu_out_ready = 1'b1;
      drive(1, tv[i].m, tv[i].o, tv[i].a, tv[i].b);
      #1 chk("vec_rdy", bus.alu_in_ready, 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
      #1 chk("vec_not_yet", bus.alu_out_valid, 0);
      chk("vec_zero", bus.alu_out, 0);
      @(negedge clk);
      #1 chk("vec_valid", bus.alu_out_valid, 1);
      chk($sformatf("vec%0d_out", i), bus.alu_out, tv[i].exp);
    end
    chk("irq_idle", bus.alu_irq, 0);
    @(negedge clk);
    drive(1, 0, 2, 8'hF0, 8'h0F);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1 chk("irq_not_yet", bus.alu_irq, 0);
    @(negedge clk);
    #1 chk("irq_res", bus.alu_out, 8'hFF);
    chk("irq_set", bus.alu_irq, 1);
    @(negedge clk);
    drive(1, 0, 2, 8'hF0, 8'h0F);
    #1 chk("irq_sticky", bus.alu_irq, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    bus.alu_irq_clr = 1'b1;
    @(negedge clk);
    bus.alu_irq_clr = 1'b0;
    #1 chk("irq_set_wins", bus.alu_irq, 1);
    chk("irq_res2", bus.alu_out, 8'hFF);
    @(negedge clk);
    bus.alu_irq_clr = 1'b1;
    @(negedge clk);
    bus.alu_irq_clr = 1'b0;
    #1 chk("irq_clr", bus.alu_irq, 0);
    sent = 0;
    got = 0;
    stall = 0;
    full = 0;
    for (int t = 0; t < 40 && got < 4; t++) begin
      @(negedge clk);
      if (sent < 4) drive(1, s4[sent].m, s4[sent].o, s4[sent].a, s4[sent].b);
      else drive(0, 0, 0, 0, 0);
      bus.alu_out_ready = stall >= 3;
      #1;
      if (bus.alu_out_valid) begin
        if (!bus.alu_out_ready) begin
          chk("stall_hold", bus.alu_out, s4[0].exp);
          stall++;
        end else begin
          chk($sformatf("order%0d", got), bus.alu_out, s4[got].exp);
          got++;
        end
      end else chk("idle_zero", bus.alu_out, 0);
      if (bus.alu_in_valid && bus.alu_in_ready) sent++;
      else if (bus.alu_in_valid) full = 1;
    end
    chk("stall_all4", got, 4);
    chk("stall_in_ready_low", full, 1);
    @(negedge clk);
    bus.alu_out_ready = 1'b0;
    drive(1, 0, 0, 8'hF0, 8'h3C);
    @(negedge clk);
    drive(1, 1, 3, 8'hFF, 8'h02);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1 chk("inflight_valid", bus.alu_out_valid, 1);
    rst = 1'b1;
    #1 chk("midrst_valid", bus.alu_out_valid, 0);
    chk("midrst_out", bus.alu_out, 0);
    chk("midrst_rdy", bus.alu_in_ready, 0);
    chk("midrst_irq", bus.alu_irq, 0);
    chk("midrst_cnt", bus.alu_op_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.alu_out_ready = 1'b1;
    #1 chk("release_rdy_low", bus.alu_in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("no_stale", bus.alu_out_valid, 0);
      chk("release_rdy", bus.alu_in_ready, 1);
    end
    irq_e = 0;
    pclr = 0;
    cnt_e = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      set_ev = 0;
      if (q.size() > 0 && cyc >= q[0].edge_n + 1 && !q[0].seen) begin
        q[0].seen = 1;
        set_ev = q[0].val == MATCH;
      end
      irq_e = set_ev | (irq_e & !pclr);
      pclr = $urandom_range(0, 15) == 0;
      bus.alu_irq_clr = pclr;
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      bus.alu_out_ready = $urandom_range(0, 3) != 0;
      #1;
      ev = q.size() > 0 && cyc >= q[0].edge_n + 1;
      rdy_e = q.size() < 2 || bus.alu_out_ready;
      chk("r_valid", bus.alu_out_valid, ev);
      chk("r_out", bus.alu_out, ev ? q[0].val : 8'h00);
      chk("r_rdy", bus.alu_in_ready, rdy_e);
      chk("r_irq", bus.alu_irq, irq_e);
      chk("r_cnt", bus.alu_op_cnt, CNT_EN ? cnt_e : 0);
      if (ev && bus.alu_out_ready) begin
        void'(q.pop_front());
        if (cnt_e < 65535) cnt_e++;
      end
      if (bus.alu_in_valid && rdy_e) begin
        it.val = ref_op(bus.alu_mode, bus.alu_op, bus.alu_in_a, bus.alu_in_b);
        it.edge_n = cyc + 1;
        it.seen = 0;
        q.push_back(it);
      end
    end
    @(negedge clk);
    bus.alu_irq_clr = 1'b0;
    bus.alu_out_ready = 1'b1;
    drive(1, 0, 0, 8'h01, 8'h01);
`ifdef ALU_PIPE_OPCNT_EN
    repeat (70000) @(negedge clk);
    #1 chk("cnt_saturated", bus.alu_op_cnt, 16'hFFFF);
`else
    repeat (50) @(negedge clk);
    #1 chk("cnt_disabled", bus.alu_op_cnt, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have parameter IRQ_MATCH, default all ones (DATA_W bits), result value that raises the IRQ.
REQ-003 SHALL have port alu_clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port alu_rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port alu_in_valid  input  1  operation offered.
REQ-006 SHALL have port alu_in_ready  output  1  operation accepted when valid and ready are both high.
REQ-007 SHALL have port alu_mode  input  1  0 = op set A, 1 = op set B.
REQ-008 SHALL have port alu_op  input  opcode_t (2)  OP1..OP4.
REQ-009 SHALL have ports alu_in_a and alu_in_b  input  DATA_W  operands.
REQ-010 SHALL have port alu_out_valid  output  1  result available.
REQ-011 SHALL have port alu_out_ready  input  1  result consumed when valid and ready are both high.
REQ-012 SHALL have port alu_out  output  DATA_W  result.
REQ-013 SHALL have port alu_irq  output  1  sticky match interrupt.
REQ-014 SHALL have port alu_irq_clr  input  1  synchronous IRQ clear.
REQ-015 SHALL have port alu_op_cnt  output  16  completed-operation count.

Function
REQ-016 SHALL implement a 2-stage pipeline: S1 registers mode/op/operands on accept; S2 registers the computed result.
REQ-017 SHALL use set A: OP1 a&b, OP2 a&~b, OP3 a|b, OP4 a^b.
REQ-018 SHALL use set B: OP1 ~(a^b), OP2 a&b, OP3 a|~b, OP4 a+b truncated to DATA_W, carry discarded.
REQ-019 SHALL present alu_out_valid exactly 2 cycles after accept when alu_out_ready stays high, sustaining 1 op/cycle.
REQ-020 SHALL advance S1 to S2 when S2 is empty or S2 is consumed in the same cycle; alu_in_ready = !S1 valid or S1 advancing.
REQ-021 SHALL hold alu_out and alu_out_valid stable while alu_out_valid=1 and alu_out_ready=0; no op lost or duplicated under any stall pattern.
REQ-022 SHALL drive alu_out to 0 whenever alu_out_valid=0.
REQ-023 SHALL set alu_irq on the edge a result equal to IRQ_MATCH loads into S2; it stays set until cleared.
REQ-024 SHALL clear alu_irq on a rising edge with alu_irq_clr=1; if a set event occurs on the same edge, set wins.
REQ-025 SHALL keep the full pipeline accepting when alu_in_valid and alu_out_ready are both high (simultaneous in/out handshake).

Reset
REQ-026 SHALL on alu_rst=1 immediately clear S1/S2 valid, alu_out=0, alu_out_valid=0, alu_irq=0, alu_op_cnt=0, alu_in_ready=0.
REQ-027 SHALL drop in-flight operations on reset mid-operation; alu_in_ready rises on the first edge after alu_rst deasserts.

Configuration
REQ-028 SHALL, with ALU_PIPE_OPCNT_EN defined, increment alu_op_cnt on each output handshake, saturating at 16'hFFFF.
REQ-029 SHALL, without ALU_PIPE_OPCNT_EN, tie alu_op_cnt to 0 with no counter logic.

Structure
REQ-030 SHALL take opcode_t (OP1..OP4) and the mode encodings from alu_pkg.
REQ-031 SHALL place the combinational op decode in sub-module alu_pipe_core (params DATA_W; inputs mode, op, a, b; output result).

Verification
REQ-032 SHALL cover: DATA_W=8, mode 0, OP1, a=8'hF0, b=8'h3C, out_ready=1 -> alu_out=8'h30 valid exactly 2 cycles after accept.
REQ-033 SHALL cover: mode 1, OP4, a=8'hFF, b=8'h02 -> alu_out=8'h01 (carry dropped).
REQ-034 SHALL cover: 4 back-to-back ops, out_ready low for 3 cycles after first result -> first result held, alu_in_ready=0 once S1 and S2 are full, all 4 results in order.
REQ-035 SHALL cover: mode 0, OP3, a=8'hF0, b=8'h0F -> alu_irq=1; alu_irq_clr pulse with a second 8'hFF result on the same edge -> alu_irq stays 1.
REQ-036 SHALL cover: alu_rst asserted with 2 ops in flight -> alu_out_valid=0 immediately, no stale result after release, alu_op_cnt=0.
REQ-037 SHALL cover: with ALU_PIPE_OPCNT_EN, 70000 ops -> alu_op_cnt=16'hFFFF; without it -> 0.
